store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- Sits directly downstream of the store queue and upstream of the data cache write port.
- Accepts up to N_WAY retired stores per cycle from the store queue and holds them in a FIFO.
- Drains the FIFO one store at a time to the dcache through a request/ready/done handshake.
- For every finished write, returns a one-cycle completion packet carrying store_pos, so the store queue can free that entry.

Parameters:
- N_WAY, 2, max retired stores accepted per cycle.
- DEPTH, 8, FIFO entries (power of two, ≥ N_WAY).
- N_SQ, 8, store queue entries; store_pos width is $clog2(N_SQ)+1 (1-based, 0 = invalid).
- XLEN, 32, address/data width.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- ret_valid  in  N_WAY  per-lane retired-store valid; lanes are packed low-first.
- ret_addr  in  N_WAY×XLEN  store address.
- ret_data  in  N_WAY×XLEN  store data, right-aligned.
- ret_size  in  N_WAY×2  BYTE=0, HALF=1, WORD=2.
- ret_store_pos  in  N_WAY×($clog2(N_SQ)+1)  store queue slot, 1-based.
- free_slots  out  $clog2(DEPTH)+1  registered count of empty FIFO entries.
- dc_req_valid  out  1  write request to dcache.
- dc_req_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}.
- dc_req_data  out  XLEN  data shifted into byte lanes.
- dc_req_be  out  4  byte enables.
- dc_req_ready  in  1  dcache accepts the request this cycle.
- dc_wr_done  in  1  dcache write completed; one pulse per accepted request.
- cmp_valid  out  1  completion to store queue.
- cmp_store_pos  out  $clog2(N_SQ)+1  slot being freed.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset values: all outputs 0 except free_slots=DEPTH. Pointers are cleared and the FSM goes to IDLE.
- Reset mid-operation discards all buffered stores and any outstanding request. A dc_wr_done arriving after reset is ignored because the FSM is in IDLE.
- Push:
  - All valid lanes are written at head+0..k-1 in lane order; the pointer wraps modulo DEPTH.
  - Upstream guarantees popcount(ret_valid) ≤ free_slots as sampled from the previous cycle's register. Overflow is an assertion failure, and the excess lanes are dropped.
- Pop:
  - The FIFO tail is consumed only on the DONE→next transition.
  - Push and pop in the same cycle are both honoured: free_slots_next = free_slots − pushes + pops.
- FSM:
  - IDLE: if the FIFO is non-empty, go to ISSUE in the next cycle. A store pushed in cycle t can reach ISSUE at t+1 at the earliest.
  - ISSUE: dc_req_valid=1 with address, data and byte enables from the tail entry. Request fields stay stable until dc_req_ready=1. On ready, go to WAIT.
  - WAIT: dc_req_valid=0; hold until dc_wr_done=1, then go to DONE.
  - DONE: cmp_valid=1 for exactly one cycle with the tail store_pos. Pop the tail. Go to ISSUE if at least 2 entries remain (i.e. the FIFO is non-empty after the pop), otherwise go to IDLE.
  - dc_wr_done outside WAIT is ignored.
  - ready and done in the same cycle while in ISSUE is not allowed; done is only sampled in WAIT.
- Byte lanes, with off = addr[1:0]:
  - BYTE: be = 4'b0001<<off; data = {4{data[7:0]}}.
  - HALF: be = 4'b0011<<{off[1],1'b0}; data = {2{data[15:0]}}.
  - WORD: be = 4'b1111; data unchanged.
  - A misaligned HALF/WORD uses the aligned lanes above; alignment is not checked.
- Completion order equals retirement order (FIFO). At most one completion per cycle.
- Minimum store-to-completion latency with immediate ready and a 1-cycle done is 4 cycles: push t, ISSUE t+1, WAIT t+2, DONE (cmp) t+3.
- busy=0 only when the FIFO is empty and the FSM is in IDLE.
- Branch recovery has no effect: buffered stores are architecturally committed and always drain.

Test Plan:
- Single store, WORD addr 0x100 data 0xDEADBEEF pos 3, ready tied 1, done one cycle after accept:
  - Request with be=4'b1111 at t+1, cmp_valid with pos=3 at t+3.
  - free_slots goes 8→7→8.
- Two-lane push of BYTE addr 0x203 data 0xAB pos 1 and HALF addr 0x206 data 0x1234 pos 2:
  - First request be=4'b1000, data 0xABABABAB.
  - Second request be=4'b1100, data 0x12341234.
  - Completions pos 1 then pos 2.
- Fill to DEPTH=8 with ready=0:
  - free_slots reaches 0 and dc_req fields stay stable.
  - Release ready: 8 completions in push order, free_slots returns to 8.
- Simultaneous push of 1 store in the same cycle as DONE with 3 entries buffered: free_slots unchanged that cycle, no lost or duplicated pos.
- Assert reset while in WAIT with 4 entries buffered:
  - Next cycle free_slots=8, all outputs 0.
  - A late dc_wr_done produces no cmp_valid.
- Pointer wrap-around: stream 20 stores with random ready/done delays (0–5 cycles) and check that the completion sequence equals the push sequence.

Source files
------------

// File: rtl/store_commit_buffer.sv
// Store commit buffer: collects retired stores in a FIFO and drains them one at a time to the
// dcache write port, returning a completion packet with the store queue slot for each write.
module store_commit_buffer #(
    parameter int unsigned N_WAY = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned N_SQ  = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N_WAY-1:0]                    ret_valid,
    input  logic [N_WAY*XLEN-1:0]               ret_addr,
    input  logic [N_WAY*XLEN-1:0]               ret_data,
    input  logic [N_WAY*2-1:0]                  ret_size,
    input  logic [N_WAY*($clog2(N_SQ)+1)-1:0]   ret_store_pos,
    output logic [$clog2(DEPTH):0]              free_slots,
    output logic                                dc_req_valid,
    output logic [XLEN-1:0]                     dc_req_addr,
    output logic [XLEN-1:0]                     dc_req_data,
    output logic [3:0]                          dc_req_be,
    input  logic                                dc_req_ready,
    input  logic                                dc_wr_done,
    output logic                                cmp_valid,
    output logic [$clog2(N_SQ):0]               cmp_store_pos,
    output logic                                busy
);
    localparam int unsigned PW = $clog2(N_SQ) + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e state_q, state_d;
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] free_q, free_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] push_cnt;
    logic          pop;
    logic          empty;

    logic [XLEN-1:0] mem_addr [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [1:0]      mem_size [DEPTH];
    logic [PW-1:0]   mem_pos  [DEPTH];

    logic [N_WAY-1:0] lane_we;
    logic [AW-1:0]    lane_idx [N_WAY];

    logic [XLEN-1:0] t_addr, t_data, lane_data;
    logic [1:0]      t_size, off;
    logic [3:0]      lane_be;

    // Valid lanes take consecutive slots from head; lanes beyond the free count are dropped.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < N_WAY; i++) begin
            lane_we[i]  = 1'b0;
            lane_idx[i] = head_q + push_cnt[AW-1:0];
            if (ret_valid[i] && (push_cnt < free_q)) begin
                lane_we[i] = 1'b1;
                push_cnt   = push_cnt + CW'(1);
            end
        end
    end

    assign pop     = (state_q == StDone);
    assign empty   = (free_q == CW'(DEPTH));
    assign count_q = CW'(DEPTH) - free_q;
    assign free_d  = free_q - push_cnt + CW'(pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            head_q  <= '0;
            tail_q  <= '0;
            free_q  <= CW'(DEPTH);
        end else begin
            state_q <= state_d;
            head_q  <= head_q + push_cnt[AW-1:0];
            tail_q  <= tail_q + AW'(pop);
            free_q  <= free_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < N_WAY; i++) begin
            if (lane_we[i]) begin
                mem_addr[lane_idx[i]] <= ret_addr[i*XLEN +: XLEN];
                mem_data[lane_idx[i]] <= ret_data[i*XLEN +: XLEN];
                mem_size[lane_idx[i]] <= ret_size[i*2 +: 2];
                mem_pos[lane_idx[i]]  <= ret_store_pos[i*PW +: PW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!empty || (push_cnt != '0)) state_d = StIssue;
            StIssue: if (dc_req_ready) state_d = StWait;
            StWait:  if (dc_wr_done) state_d = StDone;
            // Entries left after popping the tail, counting any store pushed this cycle.
            StDone:  state_d = ((count_q + push_cnt) > CW'(1)) ? StIssue : StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign t_addr = mem_addr[tail_q];
    assign t_data = mem_data[tail_q];
    assign t_size = mem_size[tail_q];
    assign off    = t_addr[1:0];

    always_comb begin
        lane_be   = 4'b1111;
        lane_data = t_data;
        case (t_size)
            2'd0: begin
                lane_be   = 4'b0001 << off;
                lane_data = {4{t_data[7:0]}};
            end
            2'd1: begin
                lane_be   = 4'b0011 << {off[1], 1'b0};
                lane_data = {2{t_data[15:0]}};
            end
            default: begin
                lane_be   = 4'b1111;
                lane_data = t_data;
            end
        endcase
    end

    always_comb begin
        dc_req_valid  = 1'b0;
        dc_req_addr   = '0;
        dc_req_data   = '0;
        dc_req_be     = '0;
        cmp_valid     = 1'b0;
        cmp_store_pos = '0;
        unique case (state_q)
            StIssue: begin
                dc_req_valid = 1'b1;
                dc_req_addr  = {t_addr[XLEN-1:2], 2'b00};
                dc_req_data  = lane_data;
                dc_req_be    = lane_be;
            end
            StDone: begin
                cmp_valid     = 1'b1;
                cmp_store_pos = mem_pos[tail_q];
            end
            default: ;
        endcase
    end

    assign free_slots = free_q;
    assign busy       = !empty || (state_q != StIdle);

    overflow_a: assert property (@(posedge clock) disable iff (reset)
        $countones(ret_valid) <= int'(free_q));

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: scoreboarded requests/completions, a randomisable dcache
// responder and one task per scenario.
module tb_store_commit_buffer;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ret_valid = '0;
    logic [63:0] ret_addr = '0;
    logic [63:0] ret_data = '0;
    logic [3:0]  ret_size = '0;
    logic [7:0]  ret_store_pos = '0;
    logic [3:0]  free_slots;
    logic        dc_req_valid;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_data;
    logic [3:0]  dc_req_be;
    logic        dc_req_ready;
    logic        dc_wr_done;
    logic        cmp_valid;
    logic [3:0]  cmp_store_pos;
    logic        busy;

    int total = 0;
    int bad = 0;

    req_t       req_q[$];
    logic [3:0] pos_q[$];

    bit   rdy_hold = 0, rdy_rand = 0, done_rand = 0, done_hold = 0, resp_rst = 0;
    logic manual_done = 1'b0;
    int   rdy_wait = -1, done_wait = -1;
    bit   acc_pend = 0;
    logic gen_done;

    store_commit_buffer #(.N_WAY(2), .DEPTH(8), .N_SQ(8), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_data(ret_data),
        .ret_size(ret_size), .ret_store_pos(ret_store_pos),
        .free_slots(free_slots),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
        .dc_req_be(dc_req_be), .dc_req_ready(dc_req_ready), .dc_wr_done(dc_wr_done),
        .cmp_valid(cmp_valid), .cmp_store_pos(cmp_store_pos), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic req_t model(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] sz);
        req_t r;
        r.addr = a & 32'hFFFF_FFFC;
        case (sz)
            2'd0: begin
                case (a[1:0])
                    2'd0:    r.be = 4'h1;
                    2'd1:    r.be = 4'h2;
                    2'd2:    r.be = 4'h4;
                    default: r.be = 4'h8;
                endcase
                r.data = d[7:0] * 32'h0101_0101;
            end
            2'd1: begin
                r.be   = a[1] ? 4'hC : 4'h3;
                r.data = d[15:0] * 32'h0001_0001;
            end
            default: begin
                r.be   = 4'hF;
                r.data = d;
            end
        endcase
        return r;
    endfunction

    task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input logic [3:0] pos);
        ret_valid[lane]            = 1'b1;
        ret_addr[lane*32 +: 32]    = a;
        ret_data[lane*32 +: 32]    = d;
        ret_size[lane*2 +: 2]      = sz;
        ret_store_pos[lane*4 +: 4] = pos;
        req_q.push_back(model(a, d, sz));
        pos_q.push_back(pos);
    endtask

    // dcache model: ready after 0..5 cycles of valid, done 0..5 cycles into WAIT
    initial begin
        dc_req_ready = 1'b0;
        dc_wr_done   = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            gen_done = 1'b0;
            if (resp_rst) begin
                rdy_wait     = -1;
                done_wait    = -1;
                acc_pend     = 0;
                dc_req_ready = 1'b0;
            end else begin
                if (!done_hold) begin
                    if (acc_pend) begin
                        done_wait = done_rand ? int'($urandom_range(0, 5)) : 0;
                        acc_pend  = 0;
                    end
                    if (done_wait >= 0) begin
                        gen_done  = (done_wait == 0);
                        done_wait = done_wait - 1;
                    end
                end
                dc_req_ready = 1'b0;
                if (dc_req_valid && !rdy_hold) begin
                    if (rdy_wait < 0) rdy_wait = rdy_rand ? int'($urandom_range(0, 5)) : 0;
                    if (rdy_wait == 0) begin
                        dc_req_ready = 1'b1;
                        acc_pend     = 1;
                    end
                    rdy_wait = rdy_wait - 1;
                end
            end
            dc_wr_done = gen_done | manual_done;
        end
    end

    // Scoreboard monitor: request content/order, request stability, completion order
    req_t       prev_req;
    bit         prev_pend = 0;
    req_t       exp_req;
    logic [3:0] exp_pos;
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_pend = 0;
            end else begin
                if (prev_pend) begin
                    total++;
                    if (!dc_req_valid || ({dc_req_addr, dc_req_data, dc_req_be} !== prev_req)) begin
                        bad++;
                        $display("FAIL req_stable got v=%b %h/%h/%h want %h", dc_req_valid,
                                 dc_req_addr, dc_req_data, dc_req_be, prev_req);
                    end
                end
                if (dc_req_valid && dc_req_ready) begin
                    total++;
                    if (req_q.size() == 0) begin
                        bad++;
                        $display("FAIL req_unexpected got %h/%h/%h want none",
                                 dc_req_addr, dc_req_data, dc_req_be);
                    end else begin
                        exp_req = req_q.pop_front();
                        if ({dc_req_addr, dc_req_data, dc_req_be} !== exp_req) begin
                            bad++;
                            $display("FAIL req_content got %h/%h/%h want %h/%h/%h",
                                     dc_req_addr, dc_req_data, dc_req_be,
                                     exp_req.addr, exp_req.data, exp_req.be);
                        end
                    end
                end
                if (cmp_valid) begin
                    total++;
                    if (pos_q.size() == 0) begin
                        bad++;
                        $display("FAIL cmp_unexpected got pos=%0d want none", cmp_store_pos);
                    end else begin
                        exp_pos = pos_q.pop_front();
                        if (cmp_store_pos !== exp_pos) begin
                            bad++;
                            $display("FAIL cmp_order got pos=%0d want %0d", cmp_store_pos, exp_pos);
                        end
                    end
                end
                prev_pend = dc_req_valid && !dc_req_ready;
                prev_req  = {dc_req_addr, dc_req_data, dc_req_be};
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while ((req_q.size() != 0 || pos_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n >= 1000) begin
            bad++;
            $display("FAIL %s_drain timeout req_left=%0d pos_left=%0d want 0", name,
                     req_q.size(), pos_q.size());
        end
        total++;
        if (free_slots !== 4'd8) begin
            bad++;
            $display("FAIL %s_free_after got %0d want 8", name, free_slots);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if (free_slots !== 4'd8) begin
            bad++;
            $display("FAIL reset_free got %0d want 8", free_slots);
        end
        total++;
        if ({dc_req_valid, dc_req_addr, dc_req_data, dc_req_be, cmp_valid, cmp_store_pos, busy}
            !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b a=%h d=%h be=%h c=%b p=%0d busy=%b want 0",
                     dc_req_valid, dc_req_addr, dc_req_data, dc_req_be, cmp_valid,
                     cmp_store_pos, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        @(posedge clock); #1;
        ret_valid = '0;
        set_lane(0, 32'h100, 32'hDEAD_BEEF, 2'd2, 4'd3);
        @(negedge clock);
        total++;
        if (free_slots !== 4'd8 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_t0 got free=%0d busy=%b want 8/0", free_slots, busy);
        end
        @(posedge clock); #1;
        ret_valid = '0;
        @(negedge clock);
        total++;
        if (dc_req_valid !== 1'b1 || dc_req_be !== 4'hF || dc_req_addr !== 32'h100 ||
            dc_req_data !== 32'hDEAD_BEEF || free_slots !== 4'd7) begin
            bad++;
            $display("FAIL single_t1 got v=%b be=%h a=%h d=%h free=%0d want 1/f/100/deadbeef/7",
                     dc_req_valid, dc_req_be, dc_req_addr, dc_req_data, free_slots);
        end
        @(negedge clock);
        total++;
        if (dc_req_valid !== 1'b0 || cmp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_t2 got v=%b cmp=%b want 0/0", dc_req_valid, cmp_valid);
        end
        @(negedge clock);
        total++;
        if (cmp_valid !== 1'b1 || cmp_store_pos !== 4'd3) begin
            bad++;
            $display("FAIL single_t3 got cmp=%b pos=%0d want 1/3", cmp_valid, cmp_store_pos);
        end
        @(negedge clock);
        total++;
        if (cmp_valid !== 1'b0 || free_slots !== 4'd8 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_t4 got cmp=%b free=%0d busy=%b want 0/8/0",
                     cmp_valid, free_slots, busy);
        end
        wait_drain("single");
    endtask

    task automatic test_two_lane();
        @(posedge clock); #1;
        ret_valid = '0;
        set_lane(0, 32'h203, 32'h0000_00AB, 2'd0, 4'd1);
        set_lane(1, 32'h206, 32'h0000_1234, 2'd1, 4'd2);
        @(posedge clock); #1;
        ret_valid = '0;
        @(negedge clock);
        total++;
        if (dc_req_be !== 4'b1000 || dc_req_data !== 32'hABAB_ABAB) begin
            bad++;
            $display("FAIL two_lane_req1 got be=%b d=%h want 1000/ababab", dc_req_be, dc_req_data);
        end
        repeat (2) @(negedge clock);
        total++;
        if (cmp_valid !== 1'b1 || cmp_store_pos !== 4'd1) begin
            bad++;
            $display("FAIL two_lane_cmp1 got cmp=%b pos=%0d want 1/1", cmp_valid, cmp_store_pos);
        end
        @(negedge clock);
        total++;
        if (dc_req_be !== 4'b1100 || dc_req_data !== 32'h1234_1234) begin
            bad++;
            $display("FAIL two_lane_req2 got be=%b d=%h want 1100/12341234", dc_req_be,
                     dc_req_data);
        end
        repeat (2) @(negedge clock);
        total++;
        if (cmp_valid !== 1'b1 || cmp_store_pos !== 4'd2) begin
            bad++;
            $display("FAIL two_lane_cmp2 got cmp=%b pos=%0d want 1/2", cmp_valid, cmp_store_pos);
        end
        wait_drain("two_lane");
    endtask

    task automatic test_fill();
        @(negedge clock);
        rdy_hold = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            ret_valid = '0;
            for (int l = 0; l < 2; l++)
                set_lane(l, 32'h1000 + 32'(8 * c + 4 * l), $urandom, 2'd2, 4'(2 * c + l + 1));
        end
        @(posedge clock); #1;
        ret_valid = '0;
        @(negedge clock);
        total++;
        if (free_slots !== 4'd0) begin
            bad++;
            $display("FAIL fill_free got %0d want 0", free_slots);
        end
        repeat (4) @(negedge clock);
        total++;
        if (dc_req_valid !== 1'b1 || {dc_req_addr, dc_req_data, dc_req_be} !== req_q[0] ||
            busy !== 1'b1) begin
            bad++;
            $display("FAIL fill_hold got v=%b %h/%h/%h busy=%b want 1 %h", dc_req_valid,
                     dc_req_addr, dc_req_data, dc_req_be, busy, req_q[0]);
        end
        rdy_hold = 0;
        wait_drain("fill");
    endtask

    task automatic test_push_on_done();
        int n = 0;
        @(negedge clock);
        rdy_hold = 1;
        @(posedge clock); #1;
        ret_valid = '0;
        set_lane(0, 32'h300, 32'h1111_1111, 2'd2, 4'd4);
        set_lane(1, 32'h304, 32'h2222_2222, 2'd2, 4'd5);
        @(posedge clock); #1;
        ret_valid = '0;
        set_lane(0, 32'h308, 32'h3333_3333, 2'd2, 4'd6);
        @(posedge clock); #1;
        ret_valid = '0;
        @(negedge clock);
        rdy_hold = 0;
        while (cmp_valid !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL pod_wait timeout got cmp=%b want 1", cmp_valid);
        end
        total++;
        if (free_slots !== 4'd5) begin
            bad++;
            $display("FAIL pod_free_before got %0d want 5", free_slots);
        end
        set_lane(0, 32'h30C, 32'h4444_4444, 2'd2, 4'd7);
        @(posedge clock); #1;
        ret_valid = '0;
        total++;
        if (free_slots !== 4'd5) begin
            bad++;
            $display("FAIL pod_free_after got %0d want 5", free_slots);
        end
        wait_drain("push_on_done");
    endtask

    task automatic test_reset_in_wait();
        @(negedge clock);
        done_hold = 1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            ret_valid = '0;
            for (int l = 0; l < 2; l++)
                set_lane(l, 32'h400 + 32'(8 * c + 4 * l), $urandom, 2'd2, 4'(2 * c + l + 1));
        end
        @(posedge clock); #1;
        ret_valid = '0;
        repeat (4) @(negedge clock);
        total++;
        if (dc_req_valid !== 1'b0 || busy !== 1'b1 || free_slots !== 4'd4) begin
            bad++;
            $display("FAIL rst_wait_pre got v=%b busy=%b free=%0d want 0/1/4",
                     dc_req_valid, busy, free_slots);
        end
        reset    = 1'b1;
        resp_rst = 1;
        @(posedge clock); #1;
        reset = 1'b0;
        req_q.delete();
        pos_q.delete();
        @(negedge clock);
        total++;
        if (free_slots !== 4'd8) begin
            bad++;
            $display("FAIL rst_wait_free got %0d want 8", free_slots);
        end
        total++;
        if ({dc_req_valid, dc_req_addr, dc_req_data, dc_req_be, cmp_valid, cmp_store_pos, busy}
            !== '0) begin
            bad++;
            $display("FAIL rst_wait_outputs got v=%b c=%b p=%0d busy=%b want 0",
                     dc_req_valid, cmp_valid, cmp_store_pos, busy);
        end
        resp_rst    = 0;
        done_hold   = 0;
        manual_done = 1'b1;
        @(negedge clock);
        manual_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            total++;
            if (cmp_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_late_done got cmp=%b busy=%b want 0/0", cmp_valid, busy);
            end
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc = 0;
        int k;
        @(negedge clock);
        rdy_rand  = 1;
        done_rand = 1;
        while (sent < 20 && cyc < 2000) begin
            @(posedge clock); #1;
            ret_valid = '0;
            k = int'($urandom_range(0, 2));
            if (k > int'(free_slots)) k = int'(free_slots);
            if (k > 20 - sent) k = 20 - sent;
            for (int l = 0; l < k; l++) begin
                set_lane(l, $urandom, $urandom, 2'($urandom_range(0, 2)), 4'((sent % 8) + 1));
                sent++;
            end
            cyc++;
        end
        @(posedge clock); #1;
        ret_valid = '0;
        total++;
        if (sent != 20) begin
            bad++;
            $display("FAIL wrap_push got sent=%0d want 20", sent);
        end
        wait_drain("wrap");
        rdy_rand  = 0;
        done_rand = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_two_lane();
        test_fill();
        test_push_on_done();
        test_reset_in_wait();
        test_wrap();
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
